// File: rtl/pipeline_skid_latch_if.sv
// Valid/ready handshake bundle between an upstream stage, the skid latch and a downstream stage.
// The slave modport is the latch's view; master is the surrounding pipeline's view.
interface pipeline_skid_latch_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipeline_skid_latch.sv
// Two-entry skid latch between pipeline stages: registered in_ready/out_data, full throughput,
// synchronous flush with a saturating count of discarded payloads.
module pipeline_skid_latch #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   pipeline_skid_latch_if.slave    bus,
   input  logic                    flush,
   output logic [1:0]              occupancy,
   output logic [CNT_W-1:0]        drop_count
);

   // Encoding equals the entry count so occupancy comes straight from the state flops.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state;
   state_t            next_state;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;

   logic              in_xfer;
   logic              out_xfer;
   logic              load_main_in;
   logic              load_main_skid;
   logic              load_skid;
   logic [1:0]        drop_inc;
   logic [CNT_W:0]    drop_sum;

   assign in_xfer  = bus.in_valid & in_ready_q;
   assign out_xfer = out_valid_q & bus.out_ready;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = main_q;
   assign occupancy     = state;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state       <= next_state;
         in_ready_q  <= (next_state != TWO);
         out_valid_q <= (next_state != EMPTY);
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      next_state = state;
      if (flush) begin
         next_state = EMPTY;
      end else begin
         case (state)
            EMPTY: if (in_xfer) next_state = ONE;
            ONE: begin
               if (in_xfer && !out_xfer)      next_state = TWO;
               else if (!in_xfer && out_xfer) next_state = EMPTY;
            end
            TWO:     if (out_xfer) next_state = ONE;
            default: next_state = EMPTY;
         endcase
      end
   end

   always_comb begin
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      drop_inc       = 2'd0;
      if (flush) begin
         // An output transfer implies at least one entry, so this never underflows.
         drop_inc = occupancy + 2'(in_xfer) - 2'(out_xfer);
      end else begin
         case (state)
            EMPTY: load_main_in = in_xfer;
            ONE: begin
               load_main_in = in_xfer & out_xfer;
               load_skid    = in_xfer & ~out_xfer;
            end
            TWO:     load_main_skid = out_xfer;
            default: ;
         endcase
      end
   end

   // NOTE: payload registers are reset because out_data must read zero while reset is held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in)        main_q <= bus.in_data;
         else if (load_main_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= bus.in_data;
      end
   end

   // Increment is at most 2, so one extra carry bit is enough to detect overflow.
   assign drop_sum = {1'b0, drop_count} + (CNT_W+1)'(drop_inc);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_count <= '0;
      end else if (flush) begin
         drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end
   end

endmodule
